// File: rtl/count_sequencer.sv
// Run/stop/reload controller for a 16-bit enable counter: prescales Clk into
// count ticks, halts the counter exactly at Limit and pulses Done on completion.
module count_sequencer #(
   parameter int WIDTH = 16,
   parameter int PS_W  = 8
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             Start,
   input  logic             Stop,
   input  logic             Mode,
   input  logic [PS_W-1:0]  Prescale,
   input  logic [WIDTH-1:0] Limit,
   input  logic [WIDTH-1:0] CntQ,
   output logic             CntEn,
   output logic             CntClr_n,
   output logic             Busy,
   output logic             Done,
   output logic [1:0]       State
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CLEAR = 2'b01,
      RUN   = 2'b10,
      HOLD  = 2'b11
   } state_e;

   state_e          state_q, state_d;
   logic [PS_W-1:0] pc_q, pc_d;
   logic            clr_n_q, clr_n_d;
   logic            done_q, done_d;
   logic            hit, match;

   // NOTE: every output of this block gets a default before the case, so no
   // path can leave a variable unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      done_d  = 1'b0;
      CntEn   = 1'b0;
      hit     = (pc_q >= Prescale);
      match   = (CntQ == Limit);

      unique case (state_q)
         IDLE: begin
            if (Start && !Stop) state_d = CLEAR;
         end
         CLEAR: begin
            pc_d    = '0;
            state_d = Stop ? HOLD : RUN;
         end
         RUN: begin
            // Enable is combinational on CntQ so the tick that would pass Limit is suppressed.
            CntEn = hit && !match;
            pc_d  = hit ? '0 : pc_q + 1'b1;
            if (match) begin
               done_d  = 1'b1;
               state_d = Mode ? CLEAR : IDLE;
            end else if (Stop) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (Stop)       state_d = IDLE;
            else if (Start) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase

      clr_n_d = (state_d != CLEAR);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of the order of statements.
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q <= IDLE;
         pc_q    <= '0;
         clr_n_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         clr_n_q <= clr_n_d;
         done_q  <= done_d;
      end
   end

   assign CntClr_n = clr_n_q;
   assign Done     = done_q;
   assign Busy     = (state_q != IDLE);
   assign State    = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: a behavioural 16-bit enable counter closes the
// loop, a vector table covers single-cycle behaviour, sequences cover the rest.
module tb_count_sequencer;

   localparam logic [1:0] S_IDLE = 2'b00, S_CLEAR = 2'b01, S_RUN = 2'b10, S_HOLD = 2'b11;

   logic        Clk = 1'b0;
   logic        Clr = 1'b0;
   logic        Start = 1'b0, Stop = 1'b0, Mode = 1'b0;
   logic [7:0]  Prescale = '0;
   logic [15:0] Limit = '0;
   logic [15:0] CntQ;
   logic        CntEn, CntClr_n, Busy, Done;
   logic [1:0]  State;
   logic [15:0] cnt = '0;

   int n_vec  = 0;
   int n_fail = 0;

   count_sequencer #(.WIDTH(16), .PS_W(8)) dut (
      .Clk(Clk), .Clr(Clr), .Start(Start), .Stop(Stop), .Mode(Mode),
      .Prescale(Prescale), .Limit(Limit), .CntQ(CntQ),
      .CntEn(CntEn), .CntClr_n(CntClr_n), .Busy(Busy), .Done(Done), .State(State)
   );

   always #5 Clk = ~Clk;

   // The controlled counter: synchronous active-low clear, count enable.
   always @(posedge Clk) begin
      if (!CntClr_n)  cnt <= '0;
      else if (CntEn) cnt <= cnt + 16'd1;
   end
   assign CntQ = cnt;

   typedef struct {
      logic        start, stop, mode;
      logic [7:0]  ps;
      logic [15:0] lim;
      logic [1:0]  st;
      logic        en, clrn, busy, done;
      logic [15:0] q;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic go_cycle();
      @(negedge Clk);
      #1;
   endtask

   task automatic start_pulse();
      go_cycle();
      Start = 1'b1;
      go_cycle();
      Start = 1'b0;
      check("start->CLEAR", {30'd0, State}, {30'd0, S_CLEAR});
   endtask

   initial begin
      logic [15:0] q_exp6 [6];
      logic [31:0] en_mask, done_mask, clrn_mask;
      logic [15:0] max_q;
      logic        busy_all, seen;

      q_exp6 = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2};

      // start stop mode ps lim | state en clrn busy done q
      vq.push_back('{1'b1, 1'b0, 1'b0, 8'd0, 16'd5, S_IDLE,  1'b0, 1'b1, 1'b0, 1'b0, 16'd0});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd5, S_CLEAR, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd5, S_RUN,   1'b1, 1'b1, 1'b1, 1'b0, 16'd0});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd5, S_RUN,   1'b1, 1'b1, 1'b1, 1'b0, 16'd1});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd5, S_RUN,   1'b1, 1'b1, 1'b1, 1'b0, 16'd2});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd5, S_RUN,   1'b1, 1'b1, 1'b1, 1'b0, 16'd3});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd5, S_RUN,   1'b1, 1'b1, 1'b1, 1'b0, 16'd4});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd5, S_RUN,   1'b0, 1'b1, 1'b1, 1'b0, 16'd5});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd5, S_IDLE,  1'b0, 1'b1, 1'b0, 1'b1, 16'd5});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd5, S_IDLE,  1'b0, 1'b1, 1'b0, 1'b0, 16'd5});
      vq.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 16'd5, S_IDLE,  1'b0, 1'b1, 1'b0, 1'b0, 16'd5});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd5, S_IDLE,  1'b0, 1'b1, 1'b0, 1'b0, 16'd5});
      vq.push_back('{1'b0, 1'b1, 1'b0, 8'd0, 16'd5, S_IDLE,  1'b0, 1'b1, 1'b0, 1'b0, 16'd5});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd5, S_IDLE,  1'b0, 1'b1, 1'b0, 1'b0, 16'd5});
      vq.push_back('{1'b1, 1'b0, 1'b0, 8'd0, 16'd0, S_IDLE,  1'b0, 1'b1, 1'b0, 1'b0, 16'd5});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd0, S_CLEAR, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd0, S_RUN,   1'b0, 1'b1, 1'b1, 1'b0, 16'd0});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd0, S_IDLE,  1'b0, 1'b1, 1'b0, 1'b1, 16'd0});
      vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 16'd0, S_IDLE,  1'b0, 1'b1, 1'b0, 1'b0, 16'd0});

      // Reset held for a few edges, then released in the low phase.
      repeat (3) go_cycle();
      check("reset outputs", {26'd0, State, CntEn, CntClr_n, Busy, Done}, 32'd0);
      check("reset cnt", {16'd0, CntQ}, 32'd0);
      Clr = 1'b1;
      #1;
      check("release before edge clrn", {31'd0, CntClr_n}, 32'd0);

      // One-shot, Start+Stop together, Stop alone, Limit=0.
      foreach (vq[i]) begin
         @(negedge Clk);
         Start = vq[i].start; Stop = vq[i].stop; Mode = vq[i].mode;
         Prescale = vq[i].ps; Limit = vq[i].lim;
         #1;
         n_vec++;
         if ({State, CntEn, CntClr_n, Busy, Done, CntQ} !==
             {vq[i].st, vq[i].en, vq[i].clrn, vq[i].busy, vq[i].done, vq[i].q}) begin
            n_fail++;
            $display("FAIL vec%0d: got st=%b en=%b clrn=%b busy=%b done=%b q=%0d expected st=%b en=%b clrn=%b busy=%b done=%b q=%0d",
                     i, State, CntEn, CntClr_n, Busy, Done, CntQ,
                     vq[i].st, vq[i].en, vq[i].clrn, vq[i].busy, vq[i].done, vq[i].q);
         end
      end
      Start = 1'b0; Stop = 1'b0;

      // Prescale=3, Limit=3: ticks at RUN cycles 3,7,11, Done at 13.
      Prescale = 8'd3; Limit = 16'd3; Mode = 1'b0;
      start_pulse();
      en_mask = '0; done_mask = '0; max_q = '0;
      for (int k = 0; k < 20; k++) begin
         go_cycle();
         if (CntEn) en_mask[k] = 1'b1;
         if (Done)  done_mask[k] = 1'b1;
         if (CntQ > max_q) max_q = CntQ;
      end
      check("ps3 en pattern", en_mask, 32'h0000_0888);
      check("ps3 done pattern", done_mask, 32'h0000_2000);
      check("ps3 max cnt", {16'd0, max_q}, 32'd3);
      check("ps3 end state", {30'd0, State}, {30'd0, S_IDLE});

      // Auto-reload, Prescale=1, Limit=2: period of 6 cycles.
      Prescale = 8'd1; Limit = 16'd2; Mode = 1'b1;
      start_pulse();
      done_mask = '0; clrn_mask = '0; busy_all = 1'b1;
      for (int k = 0; k < 24; k++) begin
         go_cycle();
         check($sformatf("reload cnt k%0d", k), {16'd0, CntQ}, {16'd0, q_exp6[k % 6]});
         if (Done)      done_mask[k] = 1'b1;
         if (!CntClr_n) clrn_mask[k] = 1'b1;
         busy_all = busy_all & Busy;
      end
      check("reload done pattern", done_mask, 32'h0082_0820);
      check("reload clear pattern", clrn_mask, 32'h0082_0820);
      check("reload busy", {31'd0, busy_all}, 32'd1);
      Mode = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         go_cycle();
         if (State == S_IDLE) seen = 1'b1;
      end
      check("reload exit to IDLE", {31'd0, seen}, 32'd1);
      check("reload exit done", {31'd0, Done}, 32'd1);

      // Pause at CntQ=3 with pc=1, hold 10 cycles, resume with retained pc.
      Prescale = 8'd2; Limit = 16'd5; Mode = 1'b0;
      start_pulse();
      for (int k = 0; k <= 10; k++) begin
         go_cycle();
         if (k == 0)  check("pause run entry", {30'd0, State}, {30'd0, S_RUN});
         if (k == 10) begin
            check("pause cnt at stop", {16'd0, CntQ}, 32'd3);
            Stop = 1'b1;
         end
      end
      for (int h = 0; h < 10; h++) begin
         go_cycle();
         Stop = 1'b0;
         check($sformatf("hold h%0d", h), {13'd0, State, CntEn, Busy, CntQ},
               {13'd0, S_HOLD, 1'b0, 1'b1, 16'd3});
      end
      Start = 1'b1;
      go_cycle();
      Start = 1'b0;
      check("resume tick from kept pc", {29'd0, State, CntEn}, {29'd0, S_RUN, 1'b1});
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         go_cycle();
         if (Done) seen = 1'b1;
      end
      check("resume done", {31'd0, seen}, 32'd1);
      check("resume final cnt", {16'd0, CntQ}, 32'd5);

      // Same run, but Stop in HOLD aborts to IDLE without clear or Done.
      start_pulse();
      for (int k = 0; k <= 10; k++) begin
         go_cycle();
         if (k == 10) Stop = 1'b1;
      end
      go_cycle();
      check("abort in HOLD", {30'd0, State}, {30'd0, S_HOLD});
      go_cycle();
      Stop = 1'b0;
      check("abort to IDLE", {30'd0, State}, {30'd0, S_IDLE});
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         go_cycle();
         if (Done || !CntClr_n) seen = 1'b1;
      end
      check("abort no done/clear", {31'd0, seen}, 32'd0);
      check("abort cnt kept", {16'd0, CntQ}, 32'd3);

      // Stop in the same cycle as match: match wins, one-shot goes IDLE.
      Prescale = 8'd0; Limit = 16'd2;
      start_pulse();
      for (int k = 0; k <= 2; k++) go_cycle();
      check("match cycle cnt", {16'd0, CntQ}, 32'd2);
      Stop = 1'b1;
      go_cycle();
      Stop = 1'b0;
      check("stop+match", {29'd0, State, Done}, {29'd0, S_IDLE, 1'b1});

      // Asynchronous reset mid-RUN, in the middle of a clock phase.
      Limit = 16'd100;
      start_pulse();
      repeat (3) go_cycle();
      check("pre-reset running", {29'd0, State, CntEn}, {29'd0, S_RUN, 1'b1});
      #1;
      Clr = 1'b0;
      #1;
      check("async reset", {26'd0, State, CntEn, CntClr_n, Busy, Done}, 32'd0);
      repeat (2) go_cycle();
      Clr = 1'b1;
      #1;
      check("release clrn low", {31'd0, CntClr_n}, 32'd0);
      go_cycle();
      check("release clrn high", {13'd0, State, CntClr_n, CntQ}, {13'd0, S_IDLE, 1'b1, 16'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
